rom_read_arbiter: RTL and testbench

Round-robin arbiter that shares the dual-read-port 16x32 ROM among NREQ requesters. Each cycle it selects up to two pending requests, drives their addresses onto the ROM's two combinational read ports, and registers the returned words back to the winners with a one-cycle acknowledge. It sits between the ROM and its consumers (fetch, constant-table readers) so that no consumer drives the ROM address ports directly.

---
 rtl/rom_read_arbiter_pkg.sv | 11 +
 rtl/rom_read_arbiter_rr_pick2.sv | 39 +++
 rtl/rom_read_arbiter.sv | 88 ++++++++
 tb/tb_rom_read_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_read_arbiter_pkg.sv
// Shared defaults for the dual-port ROM read arbiter.
package rom_read_arbiter_pkg;

  localparam int NREQ_DEF         = 4;
  localparam int AW_DEF           = 4;
  localparam int DW_DEF           = 32;
  localparam int ROM_DEPTH        = 16;
  // The ROM has two read ports, so at most two requesters win per cycle.
  localparam int GRANTS_PER_CYCLE = 2;

endpackage

// File: rtl/rom_read_arbiter_rr_pick2.sv
// Round-robin two-winner picker: walks ptr, ptr+1, ... (mod NREQ) and
// returns the first eligible index for port 1 and the second for port 2.
module rr_pick2
  import rom_read_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   g1,
  output logic            g1_valid,
  output logic [PW-1:0]   g2,
  output logic            g2_valid
);

  // Circular search starting at ptr; the first two hits become the winners.
  always_comb begin
    logic [PW-1:0] idx;
    g1       = '0;
    g1_valid = 1'b0;
    g2       = '0;
    g2_valid = 1'b0;
    idx      = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (eligible[idx]) begin
        if (!g1_valid) begin
          g1       = idx;
          g1_valid = 1'b1;
        end else if (!g2_valid) begin
          g2       = idx;
          g2_valid = 1'b1;
        end
      end
      idx = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares a dual-read-port ROM among NREQ requesters: up to two round-robin
// winners per cycle, registered data and a one-cycle ack back to each winner.
module rom_read_arbiter
  import rom_read_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ*DW-1:0] rdata,
  output logic [AW-1:0]      rom_dir1,
  output logic [AW-1:0]      rom_dir2,
  input  logic [DW-1:0]      rom_dato1,
  input  logic [DW-1:0]      rom_dato2,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   g1;
  logic [PW-1:0]   g2;
  logic            g1_valid;
  logic            g2_valid;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic            busy_nxt;

  // A requester acked this cycle sits out one cycle, giving the 50% duty.
  assign eligible = req & ~ack;

  rr_pick2 #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .g1       (g1),
    .g1_valid (g1_valid),
    .g2       (g2),
    .g2_valid (g2_valid)
  );

  // Address muxes onto the two ROM ports; idle ports read address 0.
  always_comb begin
    rom_dir1 = '0;
    rom_dir2 = '0;
    if (g1_valid) rom_dir1 = addr[int'(g1)*AW +: AW];
    if (g2_valid) rom_dir2 = addr[int'(g2)*AW +: AW];
  end

  // Grant vector, next pointer (one past the last winner) and busy flag.
  always_comb begin
    grant    = '0;
    ptr_nxt  = ptr;
    if (g1_valid) grant[g1] = 1'b1;
    if (g2_valid) grant[g2] = 1'b1;
    if (g2_valid) begin
      ptr_nxt = (g2 == PW'(NREQ - 1)) ? '0 : g2 + 1'b1;
    end else if (g1_valid) begin
      ptr_nxt = (g1 == PW'(NREQ - 1)) ? '0 : g1 + 1'b1;
    end
    busy_nxt = ($countones(eligible) > GRANTS_PER_CYCLE);
  end

  // Register acks, winner data, pointer and busy; reset drops pending grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= '0;
      rdata <= '0;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      ack  <= grant;
      ptr  <= ptr_nxt;
      busy <= busy_nxt;
      if (g1_valid) rdata[int'(g1)*DW +: DW] <= rom_dato1;
      if (g2_valid) rdata[int'(g2)*DW +: DW] <= rom_dato2;
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed scenarios plus random traffic, checked
// by a queue-based scoreboard fed from a behavioural round-robin model.
module tb_rom_read_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    ack;
  logic [NREQ*DW-1:0] rdata;
  logic [AW-1:0]      rom_dir1;
  logic [AW-1:0]      rom_dir2;
  logic [DW-1:0]      rom_dato1;
  logic [DW-1:0]      rom_dato2;
  logic               busy;

  rom_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (addr),
    .ack       (ack),
    .rdata     (rdata),
    .rom_dir1  (rom_dir1),
    .rom_dir2  (rom_dir2),
    .rom_dato1 (rom_dato1),
    .rom_dato2 (rom_dato2),
    .busy      (busy)
  );

  // ROM contents: mem[a] = A000_0000 + a
  assign rom_dato1 = 32'hA000_0000 + {28'd0, rom_dir1};
  assign rom_dato2 = 32'hA000_0000 + {28'd0, rom_dir2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0]    ack;
    logic [NREQ*DW-1:0] rdata;
    logic               busy;
  } reg_exp_t;

  reg_exp_t         regq[$];
  logic [2*AW-1:0]  dirq[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: what ack/rdata/busy will read after the next edge.
  logic [NREQ-1:0] m_ack;
  logic [DW-1:0]   m_rd[NREQ];
  int              m_ptr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return addr[i*AW +: AW];
  endfunction

  task automatic model_reset();
    m_ack = '0;
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_rd[i] = '0;
  endtask

  // Applies the arbitration rules to the inputs just driven and queues the
  // expected combinational addresses and the expected registered response.
  task automatic model_step();
    logic [NREQ-1:0] elig;
    int              win[$];
    int              idx;
    logic [AW-1:0]   d1;
    logic [AW-1:0]   d2;
    reg_exp_t        e;
    elig = req & ~m_ack;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (elig[idx] && win.size() < 2) win.push_back(idx);
    end
    d1 = (win.size() > 0) ? addr_of(win[0]) : '0;
    d2 = (win.size() > 1) ? addr_of(win[1]) : '0;
    dirq.push_back({d2, d1});
    m_ack = '0;
    foreach (win[j]) begin
      m_ack[win[j]] = 1'b1;
      m_rd[win[j]]  = 32'hA000_0000 + 32'(addr_of(win[j]));
    end
    if (win.size() > 0) m_ptr = (win[win.size()-1] + 1) % NREQ;
    e.ack  = m_ack;
    e.busy = ($countones(elig) > 2);
    for (int i = 0; i < NREQ; i++) e.rdata[i*DW +: DW] = m_rd[i];
    regq.push_back(e);
  endtask

  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a);
    @(negedge clk);
    req  = r;
    addr = a;
    model_step();
  endtask

  // Random traffic obeying the hold-until-ack rule, with occasional withdrawal.
  task automatic rand_cycle();
    logic [NREQ-1:0]    r;
    logic [NREQ*AW-1:0] a;
    @(negedge clk);
    r = req;
    a = addr;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !m_ack[i]) begin
        if ($urandom_range(0, 9) == 0) r[i] = 1'b0;
      end else begin
        r[i] = ($urandom_range(0, 2) != 0);
        if (r[i]) a[i*AW +: AW] = 4'($urandom_range(0, 15));
      end
    end
    req  = r;
    addr = a;
    model_step();
  endtask

  // Monitor: ROM port addresses, sampled mid-cycle after inputs settle.
  initial begin
    logic [2*AW-1:0] d;
    forever begin
      @(negedge clk);
      #2;
      if (dirq.size() > 0) begin
        d = dirq.pop_front();
        check("rom_dir1", 128'(rom_dir1), 128'(d[AW-1:0]));
        check("rom_dir2", 128'(rom_dir2), 128'(d[2*AW-1:AW]));
      end
    end
  end

  // Monitor: registered outputs, sampled just after the rising edge.
  initial begin
    reg_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (regq.size() > 0) begin
        e = regq.pop_front();
        check("ack",   128'(ack),   128'(e.ack));
        check("rdata", 128'(rdata), 128'(e.rdata));
        check("busy",  128'(busy),  128'(e.busy));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap[NREQ];
    int maxgap;
    rst_n = 1'b1;
    req   = '0;
    addr  = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset_ack",   128'(ack),   128'(0));
    check("reset_rdata", 128'(rdata), 128'(0));
    check("reset_busy",  128'(busy),  128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 0
    drive(4'b0001, 16'h0003);
    drive(4'b0000, 16'h0000);
    check("single_ack",   128'(ack),          128'(4'b0001));
    check("single_rdata", 128'(rdata[31:0]),  128'(32'hA000_0003));

    // Two simultaneous requests
    drive(4'b0110, 16'h0950);
    drive(4'b0000, 16'h0000);
    check("pair_ack",    128'(ack),           128'(4'b0110));
    check("pair_rdata1", 128'(rdata[63:32]),  128'(32'hA000_0005));
    check("pair_rdata2", 128'(rdata[95:64]),  128'(32'hA000_0009));

    // Same address on both ports
    drive(4'b1001, 16'h7007);
    drive(4'b0000, 16'h0000);
    check("same_ack",    128'(ack),           128'(4'b1001));
    check("same_rdata0", 128'(rdata[31:0]),   128'(32'hA000_0007));
    check("same_rdata3", 128'(rdata[127:96]), 128'(32'hA000_0007));

    // Re-grant masking: requester 2 holds its request
    for (int c = 0; c < 6; c++) drive(4'b0100, 16'h0E00);
    drive(4'b0000, 16'h0000);
    drive(4'b0000, 16'h0000);

    // Reset while an ack is being presented
    drive(4'b0001, 16'h0003);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("midrst_ack",   128'(ack),   128'(0));
    check("midrst_rdata", 128'(rdata), 128'(0));
    check("midrst_busy",  128'(busy),  128'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All four held continuously from ptr=0
    req  = 4'b1111;
    addr = 16'hDCBA;
    model_step();
    #1;
    check("post_reset_first_grant", 128'(rom_dir1), 128'(4'hA));
    for (int i = 0; i < NREQ; i++) gap[i] = 0;
    maxgap = 0;
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 16'hDCBA);
      for (int i = 0; i < NREQ; i++) begin
        gap[i] = ack[i] ? 0 : gap[i] + 1;
        if (gap[i] > maxgap) maxgap = gap[i];
      end
    end
    check("max_wait", 128'(maxgap > 2), 128'(0));
    drive(4'b0000, 16'hDCBA);
    drive(4'b0000, 16'hDCBA);

    // Random traffic
    for (int c = 0; c < 400; c++) rand_cycle();

    for (int c = 0; c < 3; c++) drive(4'b0000, 16'h0000);
    @(posedge clk);
    #3;
    check("queues_drained", 128'(regq.size() + dirq.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
